uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ requesters, for example hashing cores reporting golden nonces.
- A round-robin arbiter picks one pending 32-bit word.
- The block serialises the word MSB-first into WORD_BYTES byte transmissions.
- It drives the UART's transmit/tx_byte handshake and paces each byte on is_transmitting.
- It sits between the requester cores and the uart block in the miner top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WORD_BYTES, 4, bytes sent per word (1..4); the most-significant WORD_BYTES*8 bits of req_data are used
HDR_BYTE, 8'hA0, header base byte (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
req  in  NUM_REQ  level request per requester; held until ack
req_data  in  NUM_REQ*32  word per requester; slice i = bits [32*i+31:32*i]
ack  out  NUM_REQ  one-cycle pulse: word i captured, requester may drop req/change data
uart_transmit  out  1  to uart transmit
uart_tx_byte  out  8  to uart tx_byte
uart_is_transmitting  in  1  from uart is_transmitting
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, ack=0, uart_transmit=0, uart_tx_byte=0, busy=0, rr_ptr=0.
  - Takes priority over everything, including mid-word. No partial byte is resumed; the uart may finish any byte already started.
- Round-robin winner:
  - The first set bit of req, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - On grant, rr_ptr <= winner+1, wrapping NUM_REQ-1 to 0.
- FSM states: IDLE, ARM, PULSE, WAIT.
- IDLE: if req != 0 at a posedge:
  - shreg <= req_data[winner];
  - byte_cnt <= WORD_BYTES;
  - ack[winner] <= 1 for exactly one cycle;
  - go to ARM.
  - If req == 0, stay in IDLE.
- ARM: if uart_is_transmitting==0, go to PULSE. Otherwise hold in ARM, so an external/previous transfer finishes first.
- PULSE:
  - uart_transmit=1 for exactly this one cycle (registered Moore decode).
  - uart_tx_byte = shreg[31:24], stable during PULSE and WAIT.
  - Next state is WAIT unconditionally.
- WAIT:
  - Wait for uart_is_transmitting==0.
  - Then shreg <= shreg<<8 and byte_cnt <= byte_cnt-1.
  - If byte_cnt was 1, go to IDLE; otherwise go to ARM.
  - WAIT never exits on the first WAIT cycle, since is_transmitting is high there; no extra guard is needed.
- uart_transmit never stays high for two consecutive cycles. This satisfies the uart's recover state, which waits for transmit to drop.
- Latency (uart idle): req sampled at edge 0 → ack and ARM at cycle 1 → PULSE at cycle 2.
- Between bytes: one ARM cycle plus PULSE, i.e. ≥2 cycles after is_transmitting falls.
- req is not re-examined while busy. A req dropped before grant is simply not served. New requests wait for the next IDLE.
- Simultaneous requests: exactly one ack per word. Every other requester is served within NUM_REQ words.
- byte_cnt width is 3 bits; shreg is 32 bits.

Optional Feature:
UART_TX_ARB_HDR_EN
- Defined: each word is preceded by one header byte, HDR_BYTE | winner (e.g. 8'hA2 for requester 2).
  - At grant, byte_cnt <= WORD_BYTES+1.
  - A hdr_pending flag selects the header for the first PULSE.
  - The shreg shift is skipped after the header byte.
- Undefined: no header and no hdr_pending logic; the byte stream is payload only.

Decomposition:
Package uart_arb_pkg holds:
- FSM state encoding (IDLE=0, ARM=1, PULSE=2, WAIT=3);
- HDR_BYTE default;
- the byte_cnt width constant.

Sub-module rr_arbiter (NUM_REQ): inputs req and rr_ptr; outputs a one-hot grant and a binary winner index. Purely combinational; the pointer register lives in the parent.

Test Plan:
1. Single word: req=4'b0001, data0=32'hDEADBEEF, uart model idle → ack[0] one cycle; bytes DE,AD,BE,EF, each with one-cycle uart_transmit; busy drops after the last byte.
2. Contention: req=4'b1011 held, each requester drops req on its ack → grant order 0,1,3, then 0 again if re-raised; never two ack bits set.
3. Back-pressure: uart_is_transmitting forced high 500 cycles before the first byte → FSM holds in ARM with uart_transmit=0; PULSE occurs 1 cycle after release.
4. Reset mid-word: rst_n=0 during the 2nd byte's WAIT → next cycle state IDLE, busy=0, uart_transmit=0, rr_ptr=0; a pending req=4'b0100 is granted with ack[2].
5. WORD_BYTES=1, data 32'h12345678 → a single byte 8'h12 is sent.
6. With UART_TX_ARB_HDR_EN: req[2], data 32'h00000001 → bytes A2,00,00,00,01.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM encoding,
// default header byte and byte counter width.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_PULSE = 2'd2,
      ST_WAIT  = 2'd3
   } arb_state_e;

   localparam logic [7:0] HDR_BYTE_DEF = 8'hA0;
   localparam int         BYTE_CNT_W   = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   winner_o
);

   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // One extra bit so the wrap works for non-power-of-two NUM_REQ.
         sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         idx = sum[IDX_W-1:0];
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            winner_o     = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ requesters; each granted 32-bit
// word is sent MSB-first as WORD_BYTES bytes. Define UART_TX_ARB_HDR_EN to
// prefix every word with a header byte HDR_BYTE | winner.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         NUM_REQ    = 4,
   parameter int         WORD_BYTES = 4,
   parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_data,
   output logic [NUM_REQ-1:0]    ack,
   output logic                  uart_transmit,
   output logic [7:0]            uart_tx_byte,
   input  logic                  uart_is_transmitting,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..8");
   end
   if (WORD_BYTES < 1 || WORD_BYTES > 4) begin : g_bad_word_bytes
      $error("uart_tx_arbiter: WORD_BYTES must be 1..4");
   end
   // The winner index is OR-ed into the low three header bits.
   if ((HDR_BYTE & 8'h07) != 8'h00) begin : g_bad_hdr
      $error("uart_tx_arbiter: HDR_BYTE low three bits must be zero");
   end

   arb_state_e              state_q;
   logic [31:0]             shreg_q;
   logic [BYTE_CNT_W-1:0]   byte_cnt_q;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]      ack_q;
   logic                    xmit_q;
   logic [7:0]              tx_byte_q;
   logic [NUM_REQ-1:0]      grant;
   logic [IDX_W-1:0]        winner;
   logic [31:0]             word_sel;
   logic [7:0]              next_byte;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (grant),
      .winner_o (winner)
   );

   always_comb begin
      word_sel = req_data[32*int'(winner) +: 32];
      rr_ptr_d = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
   end

`ifdef UART_TX_ARB_HDR_EN
   logic       hdr_pending_q;
   logic [7:0] hdr_byte_q;

   always_comb next_byte = hdr_pending_q ? hdr_byte_q : shreg_q[31:24];
`else
   always_comb next_byte = shreg_q[31:24];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         byte_cnt_q <= '0;
         rr_ptr_q   <= '0;
         ack_q      <= '0;
         xmit_q     <= 1'b0;
         tx_byte_q  <= '0;
`ifdef UART_TX_ARB_HDR_EN
         hdr_pending_q <= 1'b0;
         hdr_byte_q    <= '0;
`endif
      end else begin
         ack_q  <= '0;
         xmit_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  shreg_q  <= word_sel;
                  ack_q    <= grant;
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= ST_ARM;
`ifdef UART_TX_ARB_HDR_EN
                  byte_cnt_q    <= BYTE_CNT_W'(WORD_BYTES + 1);
                  hdr_pending_q <= 1'b1;
                  hdr_byte_q    <= HDR_BYTE | 8'(winner);
`else
                  byte_cnt_q <= BYTE_CNT_W'(WORD_BYTES);
`endif
               end
            end
            ST_ARM: begin
               // Hold off until any transfer already on the wire completes.
               if (!uart_is_transmitting) begin
                  state_q   <= ST_PULSE;
                  xmit_q    <= 1'b1;
                  tx_byte_q <= next_byte;
               end
            end
            ST_PULSE: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!uart_is_transmitting) begin
`ifdef UART_TX_ARB_HDR_EN
                  if (hdr_pending_q) begin
                     hdr_pending_q <= 1'b0;
                  end else begin
                     shreg_q <= shreg_q << 8;
                  end
`else
                  shreg_q <= shreg_q << 8;
`endif
                  byte_cnt_q <= byte_cnt_q - 1'b1;
                  state_q    <= (byte_cnt_q == BYTE_CNT_W'(1)) ? ST_IDLE : ST_ARM;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack           = ack_q;
   assign uart_transmit = xmit_q;
   assign uart_tx_byte  = tx_byte_q;
   assign busy          = (state_q != ST_IDLE);
   assign state_dbg     = state_q;

endmodule
